// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter in front of one shared storage register.
// Each granted access is a fixed 3-cycle GRANT/DONE handshake; writes commit through reg_d.
module sram_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             we0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             req1,
    input  logic             we1,
    input  logic [WIDTH-1:0] wdata1,
    input  logic [WIDTH-1:0] reg_q,
    output logic [WIDTH-1:0] reg_d,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] rdata,
    output logic [7:0]       wr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic             take_s;
    logic             win_s;
    logic             last_r;     // requester granted most recently
    logic             owner_r;
    logic             we_r;
    logic [WIDTH-1:0] wdata_r;

    // Next-state and arbitration: a lone request always wins, a tie goes away from last_r.
    always_comb begin
        state_s = state_r;
        take_s  = 1'b0;
        win_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (req0 && req1) begin
                    take_s = 1'b1;
                    win_s  = ~last_r;
                end else if (req0) begin
                    take_s = 1'b1;
                    win_s  = 1'b0;
                end else if (req1) begin
                    take_s = 1'b1;
                    win_s  = 1'b1;
                end else begin
                    take_s = 1'b0;
                    win_s  = 1'b0;
                end
                state_s = take_s ? GRANT : IDLE;
            end
            GRANT:   state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Storage feed: hold reg_q except while a latched write is in GRANT.
    always_comb begin
        reg_d = reg_q;
        if (reset) begin
            reg_d = {WIDTH{1'b0}};
        end else if ((state_r == GRANT) && we_r) begin
            reg_d = wdata_r;
        end else begin
            reg_d = reg_q;
        end
    end

    // State register, transaction latch and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            last_r   <= 1'b1;
            owner_r  <= 1'b0;
            we_r     <= 1'b0;
            wdata_r  <= {WIDTH{1'b0}};
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata    <= {WIDTH{1'b0}};
            wr_count <= 8'd0;
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (take_s) begin
                        owner_r <= win_s;
                        last_r  <= win_s;
                        we_r    <= win_s ? we1 : we0;
                        wdata_r <= win_s ? wdata1 : wdata0;
                        gnt0    <= ~win_s;
                        gnt1    <= win_s;
                    end else begin
                        gnt0 <= 1'b0;
                        gnt1 <= 1'b0;
                    end
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                end
                GRANT: begin
                    ack0 <= ~owner_r;
                    ack1 <= owner_r;
                    if (we_r) begin
                        wr_count <= wr_count + 8'd1;
                    end else begin
                        rdata <= reg_q;
                    end
                end
                DONE: begin
                    gnt0 <= 1'b0;
                    gnt1 <= 1'b0;
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                end
                default: begin
                    gnt0 <= 1'b0;
                    gnt1 <= 1'b0;
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: vector table, directed corner sequences,
// and randomized traffic compared against a transaction-level reference model.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset, req0, we0, req1, we1;
    logic [15:0] wdata0, wdata1, reg_q, reg_d, rdata;
    logic        gnt0, gnt1, ack0, ack1;
    logic [7:0]  wr_count;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .wdata1(wdata1),
        .reg_q(reg_q), .reg_d(reg_d),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata(rdata), .wr_count(wr_count)
    );

    // external storage register that captures reg_d every edge
    always_ff @(posedge clk) reg_q <= reg_d;

    // reference model: cycles into the current transaction (0 = free)
    int          m_phase = 0, m_owner = 0, m_ptr = 0, m_we = 0, m_cnt = 0;
    logic [15:0] m_wd = 16'd0, m_mem = 16'd0, m_rd = 16'd0;

    function automatic logic [15:0] m_regd();
        if (reset) return 16'd0;
        if (m_phase == 1 && m_we == 1) return m_wd;
        return m_mem;
    endfunction

    task automatic model_edge();
        logic [15:0] old_mem;
        int w;
        old_mem = m_mem;
        if (reset) begin
            m_phase = 0; m_ptr = 0; m_rd = 16'd0; m_cnt = 0; m_mem = 16'd0;
        end else begin
            m_mem = m_regd();
            if (m_phase == 0) begin
                if (req0 || req1) begin
                    w       = (req0 && req1) ? m_ptr : (req0 ? 0 : 1);
                    m_owner = w;
                    m_ptr   = 1 - w;
                    m_we    = (w == 0) ? int'(we0) : int'(we1);
                    m_wd    = (w == 0) ? wdata0 : wdata1;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (m_we == 1) m_cnt = (m_cnt + 1) % 256;
                else m_rd = old_mem;
                m_phase = 2;
            end else begin
                m_phase = 0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // one clock: advance model with the inputs now applied, then sample at negedge
    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_model();
        chk("m_gnt0", 32'(gnt0), 32'(m_phase != 0 && m_owner == 0));
        chk("m_gnt1", 32'(gnt1), 32'(m_phase != 0 && m_owner == 1));
        chk("m_ack0", 32'(ack0), 32'(m_phase == 2 && m_owner == 0));
        chk("m_ack1", 32'(ack1), 32'(m_phase == 2 && m_owner == 1));
        chk("m_rdata", 32'(rdata), 32'(m_rd));
        chk("m_wr_count", 32'(wr_count), 32'(m_cnt));
        chk("m_reg_q", 32'(reg_q), 32'(m_mem));
        chk("m_reg_d", 32'(reg_d), 32'(m_regd()));
    endtask

    task automatic idle_inputs();
        reset = 1'b0; req0 = 1'b0; we0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
    endtask

    typedef struct {
        logic        rst, r0, w0;
        logic [15:0] d0;
        logic        r1, w1;
        logic [15:0] d1;
        logic        g0, g1, a0, a1;
        logic [15:0] rd;
        logic [7:0]  cnt;
        logic [15:0] q;
    } vec_t;

    vec_t       tbl[17];
    int         order[$];
    logic       both_seen, p0, p1;
    logic [15:0] last_wd;

    initial begin
        idle_inputs();
        reset = 1'b1; wdata0 = 16'd0; wdata1 = 16'd0;

        // rst r0 w0 d0 r1 w1 d1 | g0 g1 a0 a1 rdata cnt reg_q
        tbl[0]  = '{1'b1,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,8'd0,16'h0000};
        tbl[1]  = '{1'b0,1'b1,1'b1,16'hA5A5,1'b0,1'b0,16'h0000, 1'b1,1'b0,1'b0,1'b0,16'h0000,8'd0,16'h0000};
        tbl[2]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,1'b0,1'b1,1'b0,16'h0000,8'd1,16'hA5A5};
        tbl[3]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,8'd1,16'hA5A5};
        tbl[4]  = '{1'b0,1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b0,1'b1,1'b0,1'b0,16'h0000,8'd1,16'hA5A5};
        tbl[5]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,1'b1,1'b0,1'b1,16'hA5A5,8'd1,16'hA5A5};
        tbl[6]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,1'b0,1'b0,1'b0,16'hA5A5,8'd1,16'hA5A5};
        tbl[7]  = '{1'b0,1'b1,1'b1,16'h1234,1'b0,1'b0,16'h0000, 1'b1,1'b0,1'b0,1'b0,16'hA5A5,8'd1,16'hA5A5};
        tbl[8]  = '{1'b0,1'b1,1'b1,16'hFFFF,1'b0,1'b0,16'h0000, 1'b1,1'b0,1'b1,1'b0,16'hA5A5,8'd2,16'h1234};
        tbl[9]  = '{1'b0,1'b0,1'b0,16'hFFFF,1'b0,1'b0,16'h0000, 1'b0,1'b0,1'b0,1'b0,16'hA5A5,8'd2,16'h1234};
        tbl[10] = '{1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,1'b0,1'b0,1'b0,16'hA5A5,8'd2,16'h1234};
        tbl[11] = '{1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,1'b0,1'b1,1'b0,16'h1234,8'd2,16'h1234};
        tbl[12] = '{1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h1234,8'd2,16'h1234};
        tbl[13] = '{1'b0,1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b0,1'b1,1'b0,1'b0,16'h1234,8'd2,16'h1234};
        tbl[14] = '{1'b0,1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b0,1'b1,1'b0,1'b1,16'h1234,8'd2,16'h1234};
        tbl[15] = '{1'b0,1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h1234,8'd2,16'h1234};
        tbl[16] = '{1'b0,1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b1,1'b0,1'b0,1'b0,16'h1234,8'd2,16'h1234};

        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            reset = tbl[i].rst; req0 = tbl[i].r0; we0 = tbl[i].w0; wdata0 = tbl[i].d0;
            req1 = tbl[i].r1; we1 = tbl[i].w1; wdata1 = tbl[i].d1;
            tick();
            chk($sformatf("v%0d_gnt0", i), 32'(gnt0), 32'(tbl[i].g0));
            chk($sformatf("v%0d_gnt1", i), 32'(gnt1), 32'(tbl[i].g1));
            chk($sformatf("v%0d_ack0", i), 32'(ack0), 32'(tbl[i].a0));
            chk($sformatf("v%0d_ack1", i), 32'(ack1), 32'(tbl[i].a1));
            chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(tbl[i].rd));
            chk($sformatf("v%0d_wr_count", i), 32'(wr_count), 32'(tbl[i].cnt));
            chk($sformatf("v%0d_reg_q", i), 32'(reg_q), 32'(tbl[i].q));
        end

        // both requests held through reset: grant order alternates starting with 0
        idle_inputs(); reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
        tick();
        reset = 1'b0; both_seen = 1'b0; p0 = 1'b0; p1 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (gnt0 && gnt1) both_seen = 1'b1;
            if (gnt0 && !p0) order.push_back(0);
            if (gnt1 && !p1) order.push_back(1);
            p0 = gnt0; p1 = gnt1;
        end
        chk("rr_grants", 32'(order.size()), 32'd4);
        for (int k = 0; k < order.size() && k < 4; k++)
            chk($sformatf("rr_order%0d", k), 32'(order[k]), 32'(k % 2));
        chk("rr_exclusive", 32'(both_seen), 32'd0);

        // 256 back-to-back writes from requester 0: counter wraps to 0
        idle_inputs(); reset = 1'b1;
        tick();
        reset = 1'b0; req0 = 1'b1; we0 = 1'b1;
        for (int n = 0; n < 256; n++) begin
            last_wd = 16'(n * 16'd97 + 16'd3);
            wdata0 = last_wd;
            tick(); tick(); tick();
            if (n == 254) chk("wrap_cnt255", 32'(wr_count), 32'd255);
        end
        req0 = 1'b0;
        tick();
        chk("wrap_cnt0", 32'(wr_count), 32'd0);
        chk("wrap_reg_q", 32'(reg_q), 32'(last_wd));

        // reset seen at the edge that would enter DONE of a requester 1 write
        idle_inputs(); reset = 1'b1;
        tick();
        reset = 1'b0; req1 = 1'b1; we1 = 1'b1; wdata1 = 16'h5A5A;
        tick();
        chk("abort_gnt1", 32'(gnt1), 32'd1);
        reset = 1'b1; req1 = 1'b0;
        tick();
        chk("abort_outs", {gnt0, gnt1, ack0, ack1}, 32'd0);
        chk("abort_cnt", 32'(wr_count), 32'd0);
        chk("abort_reg_q", 32'(reg_q), 32'd0);
        reset = 1'b0;
        tick();
        chk("abort_noack1", 32'(ack1), 32'd0);
        req0 = 1'b1; we0 = 1'b0;
        tick();
        chk("abort_idle_gnt0", {gnt0, gnt1}, 32'd2);

        // randomized traffic against the reference model
        idle_inputs(); reset = 1'b1;
        tick();
        for (int r = 0; r < 600; r++) begin
            reset  = ($urandom_range(0, 39) == 0);
            req0   = 1'($urandom_range(0, 1));
            req1   = 1'($urandom_range(0, 1));
            we0    = 1'($urandom_range(0, 1));
            we1    = 1'($urandom_range(0, 1));
            wdata0 = 16'($urandom);
            wdata1 = 16'($urandom);
            tick();
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
